rr_decoder_arbiter: RTL and testbench

RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

---
 rtl/rr_decoder_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for eight requesters. The grant is reported both as a
// 3-to-8 decoder select/enable and as the matching one-hot vector, all registered.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,      // early release by the current owner ("release" is a reserved word)
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [2:0] sel_reg, sel_next;
  logic       en_reg, en_next;
  logic [7:0] grant_reg, grant_next;
  logic       busy_reg, busy_next;
  logic       timeout_reg, timeout_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] hcnt_reg, hcnt_next;

  logic [15:0] rot_wide;
  logic [7:0]  rot;
  logic [2:0]  offset;
  logic [2:0]  winner;
  logic        hold_done;
  logic        owner_req;

  // Rotate the request vector so bit 0 is the pointer position; the lowest set bit wins.
  assign rot_wide = {req, req} >> ptr_reg;
  assign rot      = rot_wide[7:0];

  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) offset = 3'(k);
    end
  end

  assign winner    = ptr_reg + offset;
  assign hold_done = (hcnt_reg == HOLD_LAST);
  assign owner_req = req[sel_reg];

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    en_next      = en_reg;
    busy_next    = busy_reg;
    timeout_next = 1'b0;
    ptr_next     = ptr_reg;
    hcnt_next    = hcnt_reg;
    case (state_reg)
      GRANT: begin
        if (rel || !owner_req || hold_done) begin
          state_next   = GAP;
          en_next      = 1'b0;
          busy_next    = 1'b0;
          ptr_next     = sel_reg + 3'd1;
          // Release and a dropped request both outrank the hold limit as exit causes.
          timeout_next = hold_done && !rel && owner_req;
        end else begin
          hcnt_next = hcnt_reg + 8'd1;
        end
      end
      default: begin
        if (req != 8'h00) begin
          state_next = GRANT;
          sel_next   = winner;
          en_next    = 1'b1;
          busy_next  = 1'b1;
          hcnt_next  = 8'd0;
        end else begin
          state_next = IDLE;
          en_next    = 1'b0;
          busy_next  = 1'b0;
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign grant_next[gi] = en_next && (sel_next == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sel_reg     <= 3'd0;
      en_reg      <= 1'b0;
      grant_reg   <= 8'h00;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      ptr_reg     <= 3'd0;
      hcnt_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      en_reg      <= en_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
      ptr_reg     <= ptr_next;
      hcnt_reg    <= hcnt_next;
    end
  end

  assign sel     = sel_reg;
  assign en      = en_reg;
  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with MAX_HOLD=4; outputs checked 1ns after each edge.
module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [2:0] sel;
  logic       en;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_dec;

  rr_decoder_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .sel(sel), .en(en), .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    $display("[TB] %s obs=%h exp=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoder consistency on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      exp_dec = en ? (8'h01 << sel) : 8'h00;
      tests++;
      assert (grant === exp_dec) else begin
        fails++;
        $error("FAIL decode observed=%h expected=%h", grant, exp_dec);
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 8'h00; rel = 1'b0;
    tick(); tick();
    chk("rst_grant", grant, 8'h00);
    chk("rst_sel", {5'd0, sel}, 8'h00);
    chk("rst_en_busy_to", {5'd0, en, busy, timeout}, 8'h00);

    // Single request from idle
    rst_n = 1'b1; req = 8'h20;
    tick();
    chk("single_grant", grant, 8'h20);
    chk("single_sel", {5'd0, sel}, 8'h05);
    chk("single_en_busy", {6'd0, en, busy}, 8'h03);
    rel = 1'b1;
    tick();
    chk("single_gap_grant", grant, 8'h00);
    chk("single_gap_busy", {7'd0, busy}, 8'h00);
    rel = 1'b0; req = 8'h00;
    tick();
    chk("single_idle_grant", grant, 8'h00);
    chk("single_idle_sel_hold", {5'd0, sel}, 8'h05);

    // Round-robin with all requesting, starting from ptr=0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr_grant_%0d", i), grant, 8'h01 << (i % 8));
      rel = 1'b1;
      tick();
      chk($sformatf("rr_gap_%0d", i), grant, 8'h00);
      rel = 1'b0;
    end

    // Hold limit: four grant cycles, then a timeout GAP, then re-grant
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_hold_%0d", i), grant, 8'h08);
      chk($sformatf("to_quiet_%0d", i), {7'd0, timeout}, 8'h00);
    end
    tick();
    chk("to_gap_grant", grant, 8'h00);
    chk("to_gap_pulse", {7'd0, timeout}, 8'h01);
    tick();
    chk("to_regrant", grant, 8'h08);
    chk("to_pulse_clear", {7'd0, timeout}, 8'h00);

    // Release on the hold-limit cycle suppresses timeout
    tick(); tick(); tick();
    chk("rel_limit_held", grant, 8'h08);
    rel = 1'b1;
    tick();
    chk("rel_limit_grant", grant, 8'h00);
    chk("rel_limit_no_to", {7'd0, timeout}, 8'h00);
    rel = 1'b0;
    tick();
    chk("drop_regrant", grant, 8'h08);
    req = 8'h00;
    tick();
    chk("drop_gap_grant", grant, 8'h00);
    chk("drop_gap_flags", {6'd0, busy, timeout}, 8'h00);
    tick();
    chk("drop_idle", grant, 8'h00);

    // Reset mid-grant, then priority restarts at 0; no preemption; pointer advance
    req = 8'h40;
    tick();
    chk("mid_grant", grant, 8'h40);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_grant", grant, 8'h00);
    chk("mid_rst_sel", {5'd0, sel}, 8'h00);
    chk("mid_rst_flags", {5'd0, en, busy, timeout}, 8'h00);
    rst_n = 1'b1; req = 8'h41;
    tick();
    chk("post_rst_grant", grant, 8'h01);
    req = 8'hC1;
    tick();
    chk("no_preempt", grant, 8'h01);
    req = 8'h41; rel = 1'b1;
    tick();
    chk("post_rel_gap", grant, 8'h00);
    rel = 1'b0;
    tick();
    chk("ptr_advanced", grant, 8'h40);

    req = 8'h00;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
